// File: rtl/div_twenty_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results are held from done until the next done or reset.
module div_twenty_seq #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; accepts a request on any edge with start=1
  // RUN   | one restoring step per edge; counter runs WIDTH down to 0

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_next_part;
  logic [WIDTH-1:0] w_next_q;

  // The partial remainder is always below the divisor, so it fits in WIDTH bits
  // between steps; only the shifted value and the trial need the extra bit.
  always_comb begin
    w_shift     = {r_part, r_dvd[WIDTH-1]};
    w_trial     = w_shift - {1'b0, r_dvs};
    w_qbit      = ~w_trial[WIDTH];
    w_next_part = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_next_q    = {r_q[WIDTH-2:0], w_qbit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_part  <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_part  <= '0;
            r_q     <= '0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_dvd  <= r_dvd << 1;
          r_part <= w_next_part;
          r_q    <= w_next_q;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_next_q;
            r_rem   <= w_next_part;
            r_dbz   <= (r_dvs == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_twenty_seq.sv
// Scoreboard bench for div_twenty_seq: stimulus pushes accepted requests, a negedge
// monitor pops one per done pulse and checks against plain-arithmetic expectations.
module tb_div_twenty_seq;
  localparam int W = 20;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div_twenty_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] sb_a[$];
  logic [W-1:0] sb_b[$];
  int unsigned  sb_t[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must correspond to the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_a.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] a, b, eq, er;
        int unsigned t;
        a = sb_a.pop_front();
        b = sb_b.pop_front();
        t = sb_t.pop_front();
        if (b == 0) begin
          eq = ALL1;
          er = a;
        end else begin
          eq = a / b;
          er = a % b;
        end
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        check("latency", cyc - t, W);
        check("busy_at_done", busy, 0);
        if (b != 0) begin
          check("recompose", longint'(quotient) * b + remainder, a);
          check("rem_lt_div", (remainder < b) ? 1 : 0, 1);
        end
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start released.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (!busy) begin
      sb_a.push_back(a);
      sb_b.push_back(b);
      sb_t.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      @(negedge clk);
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_quot"}, quotient, 0);
    check({tag, "_rem"}, remainder, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(20'd1000000, 20'd7);
    wait_done();

    // Reset ten cycles into a run: the run is abandoned and outputs clear.
    issue(20'd500000, 20'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrun_reset");
    sb_a.delete(); sb_b.delete(); sb_t.delete();
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    issue(20'hFFFFF, 20'd1);       wait_done();
    issue(20'd5, 20'hFFFFF);       wait_done();
    issue(20'hFFFFF, 20'hFFFFF);   wait_done();
    issue(20'd12345, 20'd0);       wait_done();

    // start during busy must be ignored without disturbing the run.
    issue(20'd777777, 20'd13);
    repeat (5) @(negedge clk);
    issue(20'd9, 20'd3);
    wait_done();
    // Back-to-back: accepted in the done cycle itself.
    issue(20'd100, 20'd9);
    wait_done();

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wait_idle();
      a = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3:       b = ALL1;
        default: b = W'($urandom);
      endcase
      issue(a, b);
    end

    for (int i = 0; i < 100 && sb_a.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
